// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable big-endian RAM with MFA/MOC handshake and alignment checking
module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  TYPE,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MOC,
  output logic        ALIGN_ERR
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [7:0] mem [0:DEPTH-1];
  logic [3:0] cnt;
  logic rw_q, err_q;
  logic [1:0] ty_q;
  logic [7:0] a_q;
  logic [31:0] d_q;
  logic commit, mis, we;
  logic [7:0] a1, a2, a3;
  logic [31:0] rd;
  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign mis = (ty_q == 2'b01 && a_q[0]) || (ty_q[1] && a_q[1:0] != 2'b00);
  assign we = commit && !rw_q && !mis && !CLR;
  assign a1 = {a_q[7:1], 1'b1};
  assign a2 = {a_q[7:2], 2'b10};
  assign a3 = {a_q[7:2], 2'b11};
  assign rd = ty_q == 2'b00 ? {24'd0, mem[a_q]} :
              ty_q == 2'b01 ? {16'd0, mem[a_q], mem[a1]} :
              {mem[a_q], mem[a1], mem[a2], mem[a3]};
  assign MOC = (state == DONE);
  assign ALIGN_ERR = MOC && err_q;
  // next state: capture on MFA, count wait states, hold DONE until MFA drops
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (MFA ? WAIT : IDLE) :
          state == WAIT ? (cnt == 4'd0 ? DONE : WAIT) :
          (MFA ? DONE : IDLE);
  end
  // state register
  always_ff @(posedge CLK)
    state <= CLR ? IDLE : nxt;
  // request capture, wait counter, read data and error flag
  always_ff @(posedge CLK)
    if (CLR) begin
      cnt <= 4'd0;
      DATA_OUT <= 32'd0;
      err_q <= 1'b0;
      rw_q <= 1'b0;
      ty_q <= 2'b00;
      a_q <= 8'd0;
      d_q <= 32'd0;
    end else begin
      if (state == IDLE && MFA) begin
        rw_q <= RW;
        ty_q <= TYPE;
        a_q <= ADDR;
        d_q <= DATA_IN;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) err_q <= mis;
      if (commit && rw_q && !mis) DATA_OUT <= rd;
    end
  // storage write, big-endian byte lanes; contents survive reset
  always_ff @(posedge CLK)
    if (we) begin
      mem[a_q] <= ty_q == 2'b00 ? d_q[7:0] : ty_q == 2'b01 ? d_q[15:8] : d_q[31:24];
      if (ty_q != 2'b00) mem[a1] <= ty_q == 2'b01 ? d_q[7:0] : d_q[23:16];
      if (ty_q[1]) begin
        mem[a2] <= d_q[15:8];
        mem[a3] <= d_q[7:0];
      end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and random checks of data_memory_ctrl against a byte-array model
module tb_data_memory_ctrl;
  localparam int WC = 2;
  logic CLK = 1'b0, CLR = 1'b1, MFA = 1'b0, RW = 1'b0;
  logic [1:0] TYPE = 2'b00;
  logic [7:0] ADDR = 8'd0;
  logic [31:0] DATA_IN = 32'd0;
  logic [31:0] DATA_OUT;
  logic MOC, ALIGN_ERR;
  int errors = 0, checks = 0;
  logic [7:0] ref_mem [256];
  logic [31:0] ref_dout = 32'd0;

  data_memory_ctrl #(.DEPTH(256), .WAIT_CYCLES(WC)) dut (
    .CLK(CLK), .CLR(CLR), .MFA(MFA), .RW(RW), .TYPE(TYPE), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MOC(MOC), .ALIGN_ERR(ALIGN_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] ty);
    return ty == 2'b00 ? 1 : ty == 2'b01 ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [1:0] ty, input logic [7:0] a);
    return (int'(a) % nbytes(ty)) != 0;
  endfunction

  task automatic model(input logic rw, input logic [1:0] ty, input logic [7:0] a, input logic [31:0] d);
    int n;
    logic [31:0] v;
    n = nbytes(ty);
    if (misal(ty, a)) return;
    if (rw) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
      ref_dout = v;
    end else
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  task automatic access(input logic rw, input logic [1:0] ty, input logic [7:0] a,
                        input logic [31:0] d, input bit drop_early = 1'b0, input bit hold = 1'b0);
    int n;
    n = 0;
    @(negedge CLK);
    MFA = 1'b1; RW = rw; TYPE = ty; ADDR = a; DATA_IN = d;
    @(posedge CLK);
    model(rw, ty, a, d);
    @(negedge CLK);
    RW = ~rw; TYPE = 2'($urandom); ADDR = ~a; DATA_IN = ~d;
    if (drop_early) MFA = 1'b0;
    while (!MOC && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(WC + 1));
    chk("moc_rise", 32'(MOC), 32'd1);
    chk("align_err", 32'(ALIGN_ERR), 32'(misal(ty, a)));
    chk("data_out", DATA_OUT, ref_dout);
    if (drop_early) begin
      @(posedge CLK); #1;
      chk("moc_pulse", 32'(MOC), 32'd0);
    end else if (!hold) begin
      @(negedge CLK);
      MFA = 1'b0;
      @(posedge CLK); #1;
      chk("moc_fall", 32'(MOC), 32'd0);
      chk("align_fall", 32'(ALIGN_ERR), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [1:0] ty;
    bit seen;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_moc", 32'(MOC), 32'd0);
    chk("rst_align", 32'(ALIGN_ERR), 32'd0);
    chk("rst_dout", DATA_OUT, 32'd0);
    @(negedge CLK);
    CLR = 1'b0;
    for (int i = 0; i < 64; i++) access(1'b0, 2'b10, 8'(i * 4), $urandom);

    access(1'b0, 2'b10, 8'h04, 32'hDEADBEEF);
    access(1'b1, 2'b10, 8'h04, 32'd0);
    chk("plan_word", DATA_OUT, 32'hDEADBEEF);
    access(1'b1, 2'b00, 8'h05, 32'd0);
    chk("plan_byte", DATA_OUT, 32'h000000AD);
    access(1'b1, 2'b01, 8'h06, 32'd0);
    chk("plan_half", DATA_OUT, 32'h0000BEEF);
    access(1'b0, 2'b00, 8'h07, 32'hFFFFFF11);
    access(1'b1, 2'b10, 8'h04, 32'd0);
    chk("plan_bytewr", DATA_OUT, 32'hDEADBE11);
    access(1'b1, 2'b10, 8'h02, 32'd0);
    chk("plan_misrd", DATA_OUT, 32'hDEADBE11);
    access(1'b0, 2'b10, 8'h01, 32'h55AA55AA);
    access(1'b1, 2'b10, 8'h00, 32'd0);
    access(1'b0, 2'b01, 8'h09, 32'h0000ABCD);
    access(1'b1, 2'b10, 8'h08, 32'd0);

    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      ty = 2'($urandom);
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      access(1'($urandom), ty, a, $urandom);
    end

    @(negedge CLK);
    MFA = 1'b1; RW = 1'b0; TYPE = 2'b10; ADDR = 8'h10; DATA_IN = 32'h12345678;
    @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK); #1;
    ref_dout = 32'd0;
    chk("clr_wait_moc", 32'(MOC), 32'd0);
    chk("clr_wait_dout", DATA_OUT, 32'd0);
    @(negedge CLK);
    CLR = 1'b0; MFA = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge CLK); #1;
      seen |= MOC;
    end
    chk("clr_no_moc", 32'(seen), 32'd0);
    access(1'b1, 2'b10, 8'h10, 32'd0);

    @(negedge CLK);
    MFA = 1'b1; RW = 1'b0; TYPE = 2'b10; ADDR = 8'h20; DATA_IN = 32'hA5A5F00F;
    @(posedge CLK);
    repeat (WC) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    @(posedge CLK); #1;
    ref_dout = 32'd0;
    chk("clr_commit_moc", 32'(MOC), 32'd0);
    chk("clr_commit_dout", DATA_OUT, 32'd0);
    @(negedge CLK);
    CLR = 1'b0; MFA = 1'b0;
    access(1'b1, 2'b10, 8'h20, 32'd0);

    access(1'b1, 2'b10, 8'h04, 32'd0, 1'b0, 1'b1);
    repeat (8) begin
      @(negedge CLK);
      RW = 1'b0; TYPE = 2'b10; ADDR = 8'h04; DATA_IN = 32'hCAFEF00D;
      @(posedge CLK); #1;
      chk("hold_moc", 32'(MOC), 32'd1);
    end
    @(negedge CLK);
    MFA = 1'b0;
    @(posedge CLK); #1;
    chk("hold_drop", 32'(MOC), 32'd0);
    access(1'b1, 2'b10, 8'h04, 32'd0);

    access(1'b0, 2'b01, 8'h30, 32'h0000A5C3, 1'b1);
    access(1'b1, 2'b01, 8'h30, 32'd0);
    access(1'b1, 2'b00, 8'h31, 32'd0, 1'b1);
    @(posedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Byte-addressable data/instruction RAM with an MFA/MOC handshake. It sits directly downstream of the MAR, which supplies the 8-bit address, and the MDR, which supplies write data. It produces read data for the MDR/instruction register inputs. The control unit requests an access with MFA and waits for MOC before latching the result.

Parameters:
DEPTH, 256, number of bytes of storage (addressed by ADDR).
WAIT_CYCLES, 2, wait states between request capture and access completion; legal range 0 to 15.

Ports:
CLK  input  1  clock, rising-edge active
CLR  input  1  reset, synchronous, active-high
MFA  input  1  memory function activate; request is held high until MOC is seen
RW  input  1  1 = read, 0 = write
TYPE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 word
ADDR  input  8  byte address (from MAR)
DATA_IN  input  32  write data (from MDR), right-justified
DATA_OUT  output  32  read data, right-justified, zero-extended
MOC  output  1  memory operation complete
ALIGN_ERR  output  1  high with MOC when the access was misaligned

Behaviour:
- Reset: synchronous to CLK, CLR active-high.
  - On reset: state = IDLE, MOC = 0, ALIGN_ERR = 0, DATA_OUT = 32'h00000000, wait counter = 0.
  - Storage contents are NOT cleared by CLR.
- Byte order: big-endian.
  - Word at address A: mem[A] = bits 31:24, mem[A+1] = 23:16, mem[A+2] = 15:8, mem[A+3] = 7:0.
  - Halfword at A: mem[A] = bits 15:8, mem[A+1] = 7:0.
- Alignment rules:
  - Halfword requires ADDR[0] = 0.
  - Word requires ADDR[1:0] = 00.
  - Because accesses are aligned, no access crosses address 255, so address wrap cannot occur.
- FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT: on a rising edge with MFA = 1. At that edge, capture ADDR, TYPE, RW and DATA_IN into internal registers; load counter = WAIT_CYCLES. Inputs changing afterwards are ignored.
  - WAIT → DONE: when counter = 0; otherwise decrement the counter and stay in WAIT.
    - On this transition, perform the access using the captured values.
    - Read: DATA_OUT is loaded. Byte and halfword reads are zero-extended.
    - Write: bytes are committed. Byte writes use DATA_IN[7:0]; halfword writes use DATA_IN[15:0].
    - Also on this transition: MOC <= 1, and ALIGN_ERR <= misaligned.
  - Misaligned access: no storage write; DATA_OUT holds its previous value; MOC still asserts, with ALIGN_ERR = 1.
  - DONE: MOC and ALIGN_ERR stay high while MFA = 1.
  - DONE → IDLE: on the first edge with MFA = 0; MOC <= 0, ALIGN_ERR <= 0.
  - DATA_OUT holds its value until the next completed read.
- Latency:
  - MFA is first sampled high at edge k; MOC is high after edge k + WAIT_CYCLES + 1.
  - Minimum request-to-request spacing is WAIT_CYCLES + 3 edges.
- MFA behaviour outside IDLE:
  - MFA dropped during WAIT: the access still completes. MOC pulses for exactly one cycle, then returns to IDLE.
  - MFA held high after DONE → IDLE: it is not re-sampled as a new request until it has been seen low for at least one edge. No back-to-back repeat without a low gap.
- Reset mid-operation:
  - CLR during WAIT aborts the access; storage is unmodified.
  - CLR in the same cycle as the commit edge takes priority: no write, and DATA_OUT = 0.
- Memory is modelled as reg [7:0] mem [0:DEPTH-1], with a single port. Only this FSM accesses it.

Test Plan:
- Reset, then MFA=1, RW=0, TYPE=10, ADDR=8'h04, DATA_IN=32'hDEADBEEF; hold MFA until MOC → MOC rises 3 edges after MFA capture. Then read word at 04 → DATA_OUT=32'hDEADBEEF, ALIGN_ERR=0.
- After the above, byte read at 8'h05 → DATA_OUT=32'h000000AD. Halfword read at 8'h06 → 32'h0000BEEF.
- Byte write of 32'hFFFFFF11 to 8'h07, then word read at 04 → 32'hDEADBE11 (only one byte changed).
- Word read at 8'h02 → MOC=1 with ALIGN_ERR=1 and DATA_OUT unchanged. A following word write at 8'h01 leaves word 00 contents unchanged.
- Start a word write of 32'h12345678 to 8'h10, assert CLR for one cycle during WAIT → MOC never asserts; a later read of 10 returns the prior contents. MOC=0 and DATA_OUT=0 immediately after CLR.
- MFA held high continuously across two operations → exactly one access occurs. Drop MFA one cycle → MOC falls; raise MFA again → a second access completes with correct latency.
